// File: rtl/axis_i2s_rx_ctrl.sv
// I2S receive packetizer: gates sample strobes with start/stop and left-channel alignment,
// buffers them in a 2-entry skid FIFO and emits AXI4-Stream beats with tlast every pkt_len samples.
module axis_i2s_rx_ctrl #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              m_axis_aclk,
   input  logic              m_axis_arst,
   input  logic              ctrl_start,
   input  logic              ctrl_stop,
   input  logic [LEN_W-1:0]  ctrl_pkt_len,
   input  logic              smp_valid,
   input  logic [DATA_W-1:0] smp_data,
   input  logic              smp_lr,
   input  logic              m_axis_tready,
   output logic              m_axis_tvalid,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic [LEN_W-1:0]  ovf_cnt,
   output logic              ovf_sticky
);

   typedef enum logic [1:0] {IDLE, ALIGN, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
   logic [LEN_W-1:0]  smp_cnt_q, smp_cnt_d;
   logic [LEN_W-1:0]  ovf_cnt_q, ovf_cnt_d;
   logic              ovf_sticky_q, ovf_sticky_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
   logic              last0_q, last0_d, last1_q, last1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop, space, take, push, drop, tlast_tag;

   always_comb begin
      pop       = (cnt_q != 2'd0) && m_axis_tready;
      space     = (cnt_q != 2'd2) || pop;
      tlast_tag = (smp_cnt_q == pkt_len_q - LEN_W'(1));

      // A stop on a packet boundary must not open a new packet with the same-cycle sample.
      take = 1'b0;
      case (state_q)
         ALIGN:   take = smp_valid && !smp_lr && !ctrl_stop;
         RUN:     take = smp_valid && !(ctrl_stop && smp_cnt_q == '0);
         DRAIN:   take = smp_valid;
         default: take = 1'b0;
      endcase
      push = take && space;
      drop = take && !space;

      state_d      = state_q;
      pkt_len_d    = pkt_len_q;
      smp_cnt_d    = smp_cnt_q;
      ovf_cnt_d    = ovf_cnt_q;
      ovf_sticky_d = ovf_sticky_q;
      dat0_d       = dat0_q;
      dat1_d       = dat1_q;
      last0_d      = last0_q;
      last1_d      = last1_q;
      cnt_d        = cnt_q;

      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               dat0_d  = smp_data;
               last0_d = tlast_tag;
            end else begin
               dat1_d  = smp_data;
               last1_d = tlast_tag;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            dat0_d  = dat1_q;
            last0_d = last1_q;
            cnt_d   = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               dat0_d  = smp_data;
               last0_d = tlast_tag;
            end else begin
               dat0_d  = dat1_q;
               last0_d = last1_q;
               dat1_d  = smp_data;
               last1_d = tlast_tag;
            end
         end
         default: ;
      endcase

      if (push)
         smp_cnt_d = tlast_tag ? '0 : smp_cnt_q + LEN_W'(1);
      if (drop) begin
         ovf_sticky_d = 1'b1;
         if (ovf_cnt_q != '1)
            ovf_cnt_d = ovf_cnt_q + LEN_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (ctrl_start && !ctrl_stop) begin
               state_d      = ALIGN;
               pkt_len_d    = (ctrl_pkt_len == '0) ? LEN_W'(1) : ctrl_pkt_len;
               smp_cnt_d    = '0;
               ovf_cnt_d    = '0;
               ovf_sticky_d = 1'b0;
            end
         end
         ALIGN: begin
            if (ctrl_stop)
               state_d = IDLE;
            else if (push)
               state_d = RUN;
         end
         RUN: begin
            if (ctrl_stop)
               state_d = (smp_cnt_q == '0 || (push && tlast_tag)) ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (push && tlast_tag)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE) || (cnt_d != 2'd0);
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_arst) begin
         state_q      <= IDLE;
         pkt_len_q    <= '0;
         smp_cnt_q    <= '0;
         ovf_cnt_q    <= '0;
         ovf_sticky_q <= 1'b0;
         busy_q       <= 1'b0;
         dat0_q       <= '0;
         dat1_q       <= '0;
         last0_q      <= 1'b0;
         last1_q      <= 1'b0;
         cnt_q        <= 2'd0;
      end else begin
         state_q      <= state_d;
         pkt_len_q    <= pkt_len_d;
         smp_cnt_q    <= smp_cnt_d;
         ovf_cnt_q    <= ovf_cnt_d;
         ovf_sticky_q <= ovf_sticky_d;
         busy_q       <= busy_d;
         dat0_q       <= dat0_d;
         dat1_q       <= dat1_d;
         last0_q      <= last0_d;
         last1_q      <= last1_d;
         cnt_q        <= cnt_d;
      end
   end

   assign m_axis_tvalid = (cnt_q != 2'd0);
   assign m_axis_tdata  = dat0_q;
   assign m_axis_tlast  = last0_q;
   assign busy          = busy_q;
   assign ovf_cnt       = ovf_cnt_q;
   assign ovf_sticky    = ovf_sticky_q;

endmodule

// File: tb/tb_axis_i2s_rx_ctrl.sv
// Directed stimulus with a scoreboard queue; a negedge monitor checks every handshaked beat.
module tb_axis_i2s_rx_ctrl;

   logic        clk = 1'b0;
   logic        arst;
   logic        ctrl_start, ctrl_stop;
   logic [15:0] ctrl_pkt_len;
   logic        smp_valid;
   logic [31:0] smp_data;
   logic        smp_lr;
   logic        tready;
   logic        tvalid;
   logic [31:0] tdata;
   logic        tlast;
   logic        busy;
   logic [15:0] ovf_cnt;
   logic        ovf_sticky;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   axis_i2s_rx_ctrl #(.DATA_W(32), .LEN_W(16)) dut (
      .m_axis_aclk   (clk),
      .m_axis_arst   (arst),
      .ctrl_start    (ctrl_start),
      .ctrl_stop     (ctrl_stop),
      .ctrl_pkt_len  (ctrl_pkt_len),
      .smp_valid     (smp_valid),
      .smp_data      (smp_data),
      .smp_lr        (smp_lr),
      .m_axis_tready (tready),
      .m_axis_tvalid (tvalid),
      .m_axis_tdata  (tdata),
      .m_axis_tlast  (tlast),
      .busy          (busy),
      .ovf_cnt       (ovf_cnt),
      .ovf_sticky    (ovf_sticky)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!arst && tvalid && tready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b with nothing expected", tdata, tlast);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("beat_data", tdata, e.d);
            check("beat_last", {31'd0, tlast}, {31'd0, e.l});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start(input logic [15:0] len);
      ctrl_start   = 1'b1;
      ctrl_pkt_len = len;
      tick();
      ctrl_start   = 1'b0;
   endtask

   task automatic stop();
      ctrl_stop = 1'b1;
      tick();
      ctrl_stop = 1'b0;
   endtask

   task automatic send(input logic lr, input logic [31:0] d);
      smp_valid = 1'b1;
      smp_lr    = lr;
      smp_data  = d;
      tick();
      smp_valid = 1'b0;
   endtask

   task automatic expect_beat(input logic [31:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic wait_drained(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || tvalid) && k < 200) begin
         tick();
         k++;
      end
      n_tests++;
      if (k >= 200) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d beats still expected, tvalid %0b", name, exp_q.size(), tvalid);
      end
   endtask

   initial begin
      arst = 1'b1; ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_pkt_len = 16'd0;
      smp_valid = 1'b0; smp_data = 32'd0; smp_lr = 1'b0; tready = 1'b1;
      idle(3);
      @(negedge clk);
      check("rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
      check("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
      tick();
      arst = 1'b0;
      idle(2);

      // Basic packet: len 4, two packets back to back.
      start(16'd4);
      for (int i = 0; i < 8; i++) begin
         expect_beat(32'h100 + i, (i == 3) || (i == 7));
         send(i[0], 32'h100 + i);
      end
      stop();
      wait_drained("basic");
      idle(2);
      check("basic_ovf", {16'd0, ovf_cnt}, 32'd0);
      check("basic_busy", {31'd0, busy}, 32'd0);

      // Alignment: the leading right sample is discarded.
      start(16'd4);
      send(1'b1, 32'hA);
      expect_beat(32'hB, 1'b0); send(1'b0, 32'hB);
      expect_beat(32'hC, 1'b0); send(1'b1, 32'hC);
      expect_beat(32'hD, 1'b0); send(1'b0, 32'hD);
      expect_beat(32'hE, 1'b1); send(1'b1, 32'hE);
      stop();
      wait_drained("align");
      check("align_ovf", {16'd0, ovf_cnt}, 32'd0);

      // Backpressure and overflow: FIFO keeps the first two, three dropped.
      tready = 1'b0;
      start(16'd8);
      for (int i = 0; i < 5; i++) begin
         if (i < 2) expect_beat(32'h200 + i, 1'b0);
         send(i[0], 32'h200 + i);
      end
      idle(2);
      @(negedge clk);
      check("bp_ovf_cnt", {16'd0, ovf_cnt}, 32'd3);
      check("bp_sticky", {31'd0, ovf_sticky}, 32'd1);
      check("bp_tvalid", {31'd0, tvalid}, 32'd1);
      check("bp_tdata_held", tdata, 32'h200);
      check("bp_busy", {31'd0, busy}, 32'd1);
      tick();
      tready = 1'b1;
      idle(3);
      for (int i = 0; i < 6; i++) begin
         expect_beat(32'h210 + i, i == 5);
         send(i[0], 32'h210 + i);
      end
      stop();
      wait_drained("bp");
      check("bp_ovf_final", {16'd0, ovf_cnt}, 32'd3);

      // Stop mid-packet: drain finishes the packet, later samples ignored.
      start(16'd4);
      check("start_clears_sticky", {31'd0, ovf_sticky}, 32'd0);
      expect_beat(32'h300, 1'b0); send(1'b0, 32'h300);
      expect_beat(32'h301, 1'b0); send(1'b1, 32'h301);
      stop();
      check("drain_busy", {31'd0, busy}, 32'd1);
      expect_beat(32'h302, 1'b0); send(1'b0, 32'h302);
      expect_beat(32'h303, 1'b1); send(1'b1, 32'h303);
      send(1'b0, 32'h304);
      send(1'b1, 32'h305);
      wait_drained("drain");
      idle(2);
      @(negedge clk);
      check("drain_idle_busy", {31'd0, busy}, 32'd0);
      tick();

      // Degenerate length 0 behaves as 1.
      start(16'd0);
      expect_beat(32'h400, 1'b1); send(1'b0, 32'h400);
      expect_beat(32'h401, 1'b1); send(1'b1, 32'h401);
      expect_beat(32'h402, 1'b1); send(1'b0, 32'h402);
      stop();
      wait_drained("len0");

      // Reset with the FIFO full.
      tready = 1'b0;
      start(16'd4);
      send(1'b0, 32'h500);
      send(1'b1, 32'h501);
      send(1'b0, 32'h502);
      @(negedge clk);
      check("pre_rst_tvalid", {31'd0, tvalid}, 32'd1);
      check("pre_rst_ovf", {16'd0, ovf_cnt}, 32'd1);
      tick();
      arst = 1'b1;
      tick();
      arst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("post_rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("post_rst_ovf", {16'd0, ovf_cnt}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      tready = 1'b1;
      send(1'b0, 32'h600);
      send(1'b1, 32'h601);
      idle(4);
      @(negedge clk);
      check("ignored_tvalid", {31'd0, tvalid}, 32'd0);
      check("ignored_busy", {31'd0, busy}, 32'd0);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_i2s_rx_ctrl.md
# axis_i2s_rx_ctrl

Packetizing controller for the I2S receive path. Takes the one-cycle sample strobe from the I2S receiver, already synchronized into the stream clock domain, and gates it with start/stop control and channel alignment. It buffers samples in a 2-entry skid FIFO and drives an AXI4-Stream master, asserting tlast every `ctrl_pkt_len` delivered samples. Samples arriving while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `DATA_W`, 32, sample/tdata width.
- `LEN_W`, 16, width of the packet length and overflow counter.

Ports:
- `m_axis_aclk`  in  1  stream clock; the only clock.
- `m_axis_arst`  in  1  reset, synchronous, active-high.
- `ctrl_start`  in  1  one-cycle start request.
- `ctrl_stop`  in  1  one-cycle stop request.
- `ctrl_pkt_len`  in  LEN_W  samples per packet; latched on accepted start; 0 is treated as 1.
- `smp_valid`  in  1  one-cycle sample strobe from the I2S receiver.
- `smp_data`  in  DATA_W  sample word, valid with `smp_valid`.
- `smp_lr`  in  1  channel tag, 0 = left, 1 = right.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tdata`  out  DATA_W  stream data.
- `m_axis_tlast`  out  1  last sample of packet.
- `busy`  out  1  high when state ≠ IDLE or FIFO not empty.
- `ovf_cnt`  out  LEN_W  count of dropped samples; saturates at all-ones.
- `ovf_sticky`  out  1  set on first drop; cleared only by reset or accepted start.

## Operation
- States:
  - IDLE: samples ignored.
  - ALIGN: waiting for the first left sample.
  - RUN: accepting samples.
  - DRAIN: stop pending, finishing the current packet.
- Transitions:
  - IDLE→ALIGN on `ctrl_start` & !`ctrl_stop`. This latches `pkt_len` (0→1), clears `smp_cnt`, `ovf_cnt` and `ovf_sticky`.
  - ALIGN→RUN on `smp_valid` & `smp_lr`==0. That sample is accepted as the first sample of the packet. Right samples in ALIGN are discarded and not counted as overflow.
  - ALIGN→IDLE on `ctrl_stop`; stop has priority over a same-cycle sample.
  - RUN→DRAIN on `ctrl_stop` when `smp_cnt` ≠ 0. RUN→IDLE on `ctrl_stop` when `smp_cnt` == 0 (packet boundary).
  - DRAIN→IDLE after the enqueue that carries tlast. DRAIN keeps accepting samples until then.
  - `ctrl_start` outside IDLE is ignored. `ctrl_stop` in IDLE or DRAIN is ignored.
- Accept/drop:
  - In RUN or DRAIN, a `smp_valid` is enqueued if FIFO count < 2, or if count == 2 with a same-cycle pop (tvalid & tready).
  - Otherwise the sample is dropped: `ovf_cnt`+1 (saturating), `ovf_sticky`←1, `smp_cnt` unchanged.
- Packet count:
  - On each enqueue, tlast_tag = (`smp_cnt` == `pkt_len`−1).
  - `smp_cnt` wraps to 0 when tlast_tag is 1, otherwise increments.
  - Only delivered samples count, so every packet has exactly `pkt_len` samples.
- FIFO: 2 entries of {data, tlast_tag}, FIFO order. The head drives `tdata`/`tlast`. Pop occurs on tvalid & tready.
- The FIFO continues to drain in IDLE; stop never discards enqueued samples.

## Timing
- All outputs reset to 0 and the state resets to IDLE. Reset mid-packet flushes the FIFO; tvalid drops the cycle after reset is sampled.
- Latency: a sample accepted in cycle t, with the FIFO empty, gives tvalid=1 in t+1 with its data. There is no combinational path from `smp_*` to `m_axis_*`.
- AXI-S rules:
  - tdata and tlast are stable while tvalid & !tready.
  - tvalid never deasserts without a handshake, except on reset.
  - No combinational path from tready to tvalid.
- Simultaneous events:
  - Push and pop in the same cycle with count 1 or 2: count is unchanged and order is preserved.
  - Start and stop in the same cycle in IDLE: both ignored.
  - A stop in the cycle after the last sample of a packet is enqueued (`smp_cnt` == 0 in RUN) goes straight to IDLE.
- `pkt_len` changes on `ctrl_pkt_len` during RUN have no effect until the next accepted start.
- `busy` is registered and reflects the state and FIFO count after the current cycle's update.

## Test plan
- **Basic packet:** `pkt_len`=4, tready=1, start, then samples L0 R1 L2 R3 L4… → 4 beats per packet with tlast on the 4th and 8th beats, tdata matching, `ovf_cnt`=0.
- **Alignment:** start, then R (0xA), L (0xB), R (0xC) → first beat is 0xB; 0xA never appears; `ovf_cnt`=0.
- **Backpressure and overflow:** `pkt_len`=8, tready=0, 5 samples → FIFO holds the first 2, `ovf_cnt`=3, `ovf_sticky`=1. Raise tready → 2 beats out with data unchanged. The packet still completes with tlast after the 8th delivered sample.
- **Stop mid-packet:** `pkt_len`=4, stop after 2 samples → state DRAIN, 2 more samples accepted, 4th beat has tlast, then IDLE. Further samples are ignored; `busy`=0 once the FIFO is empty.
- **Degenerate length:** `ctrl_pkt_len`=0 → every beat has tlast=1.
- **Reset mid-operation:** reset with the FIFO full and tvalid=1 → the next cycle has tvalid=0, `ovf_cnt`=0, state IDLE. Samples after reset are ignored until a start.
